// File: rtl/config_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : config_frame_writer
// Purpose  : Configuration loader placed directly in front of the
//            configuration-memory latch array. It hunts a 32-bit word stream
//            for SYNC_WORD, then decodes address/data word pairs. Each write
//            drives frame data onto the latch D inputs and pulses exactly one
//            latch enable, with one setup cycle before the strobe and one hold
//            cycle after it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK          in   1                          clock
//   resetn       in   1                          asynchronous active-low reset
//   in_data      in   32                         configuration word
//   in_valid     in   1                          in_data valid
//   in_ready     out  1                          word accepted this cycle
//   FrameData    out  FRAME_BITS                 latch D inputs
//   FrameStrobe  out  NUM_COLUMNS*FRAMES_PER_COL one-hot latch enables,
//                                                index = col*FRAMES_PER_COL+frame
//   sync_lock    out  1                          session active
//   busy         out  1                          SETUP/STROBE/HOLD in progress
//   err_addr     out  1                          sticky out-of-range address
//   frames_written out 16                        (CFG_FRAME_COUNT_EN only)
//                                                saturating strobe count
// Optional feature macro: CFG_FRAME_COUNT_EN
// ============================================================================
module config_frame_writer #(
  parameter int          FRAME_BITS     = 32,
  parameter int          NUM_COLUMNS    = 4,
  parameter int          FRAMES_PER_COL = 20,
  parameter int          STROBE_CYCLES  = 2,   // legal range 1..15
  parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1
) (
  input  logic                                  CLK,
  input  logic                                  resetn,
  input  logic [31:0]                           in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [FRAME_BITS-1:0]                 FrameData,
  output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0] FrameStrobe,
  output logic                                  sync_lock,
  output logic                                  busy,
  output logic                                  err_addr
`ifdef CFG_FRAME_COUNT_EN
  ,
  output logic [15:0]                           frames_written
`endif
);

  localparam int          NUM_STROBES = NUM_COLUMNS * FRAMES_PER_COL;
  localparam logic [7:0]  NUM_COLS_8  = 8'(NUM_COLUMNS);
  localparam logic [7:0]  NUM_FRMS_8  = 8'(FRAMES_PER_COL);
  localparam logic [3:0]  STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  logic                   accept;
  logic                   is_sync;
  logic [7:0]             addr_col;
  logic [7:0]             addr_frame;
  logic                   addr_bad;
  logic [15:0]            addr_idx;
  logic [15:0]            strobe_idx;   // flat strobe index latched in ADDR
  logic                   dropped;      // pending write targets a bad address
  logic [3:0]             strobe_cnt;   // remaining strobe cycles minus one
  logic [NUM_STROBES-1:0] strobe_onehot;

  assign accept     = in_valid && in_ready;
  assign is_sync    = (in_data == SYNC_WORD);
  assign addr_col   = in_data[31:24];
  assign addr_frame = in_data[7:0];
  assign addr_bad   = (addr_col >= NUM_COLS_8) || (addr_frame >= NUM_FRMS_8);
  assign addr_idx   = 16'(addr_col) * 16'(FRAMES_PER_COL) + 16'(addr_frame);

  always_comb begin
    strobe_onehot = '0;
    for (int i = 0; i < NUM_STROBES; i++) begin
      strobe_onehot[i] = (strobe_idx == 16'(i));
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state <= HUNT;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and state-decoded outputs. in_ready depends on state only.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    sync_lock  = 1'b1;
    case (state)
      HUNT: begin
        in_ready  = 1'b1;
        sync_lock = 1'b0;
        if (accept && is_sync) next_state = ADDR;
      end
      ADDR: begin
        in_ready = 1'b1;
        if (accept) begin
          if (addr_col == 8'hFF) next_state = HUNT;
          else if (!is_sync)     next_state = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (accept) next_state = dropped ? ADDR : SETUP;
      end
      SETUP: begin
        busy       = 1'b1;
        next_state = STROBE;
      end
      STROBE: begin
        busy = 1'b1;
        if (strobe_cnt == 4'd0) next_state = HOLD;
      end
      HOLD: begin
        busy       = 1'b1;
        next_state = ADDR;
      end
      default: begin
        sync_lock  = 1'b0;
        next_state = HUNT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      FrameData   <= '0;
      FrameStrobe <= '0;
      err_addr    <= 1'b0;
      strobe_idx  <= '0;
      dropped     <= 1'b0;
      strobe_cnt  <= '0;
    end else begin
      if (state == HUNT && accept && is_sync) begin
        err_addr <= 1'b0;
      end

      if (state == ADDR && accept && addr_col != 8'hFF && !is_sync) begin
        strobe_idx <= addr_idx;
        dropped    <= addr_bad;
        if (addr_bad) err_addr <= 1'b1;
      end

      if (state == DATA && accept && !dropped) begin
        FrameData <= in_data[FRAME_BITS-1:0];
      end

      if (state == SETUP) begin
        strobe_cnt <= STROBE_LOAD;
      end else if (state == STROBE && strobe_cnt != 4'd0) begin
        strobe_cnt <= strobe_cnt - 4'd1;
      end

      // Registered enable: goes high exactly when STROBE is entered and low
      // exactly when it is left, so the latch enables never glitch.
      FrameStrobe <= (next_state == STROBE) ? strobe_onehot : '0;
    end
  end

`ifdef CFG_FRAME_COUNT_EN
  // Counts at the SETUP->STROBE edge; visible on the first strobe cycle.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      frames_written <= '0;
    end else if (state == HUNT && accept && is_sync) begin
      frames_written <= '0;
    end else if (state == SETUP && frames_written != 16'hFFFF) begin
      frames_written <= frames_written + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_config_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_frame_writer
// Purpose  : Self-checking bench for config_frame_writer. dut0 uses the
//            default STROBE_CYCLES=2 and runs a table of words. dut1 uses
//            STROBE_CYCLES=1 and receives 20 back-to-back frame writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_frame_writer;

  localparam int NS = 80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0 signals
  logic          resetn;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   FrameData;
  logic [NS-1:0] FrameStrobe;
  logic          sync_lock, busy, err_addr;
  // dut1 signals
  logic          resetn1;
  logic [31:0]   in_data1;
  logic          in_valid1;
  logic          in_ready1;
  logic [31:0]   FrameData1;
  logic [NS-1:0] FrameStrobe1;
  logic          sync_lock1, busy1, err_addr1;
`ifdef CFG_FRAME_COUNT_EN
  logic [15:0]   frames_written, frames_written1;
`endif

  config_frame_writer dut0 (
    .CLK(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .sync_lock(sync_lock), .busy(busy), .err_addr(err_addr)
`ifdef CFG_FRAME_COUNT_EN
    , .frames_written(frames_written)
`endif
  );

  config_frame_writer #(.STROBE_CYCLES(1)) dut1 (
    .CLK(clk), .resetn(resetn1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .FrameData(FrameData1), .FrameStrobe(FrameStrobe1),
    .sync_lock(sync_lock1), .busy(busy1), .err_addr(err_addr1)
`ifdef CFG_FRAME_COUNT_EN
    , .frames_written(frames_written1)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int onehot_idx(input logic [NS-1:0] v);
    int r = -1;
    for (int i = 0; i < NS; i++) if (v[i]) r = i;
    return r;
  endfunction

  // dut0 strobe monitor
  int strobe_cyc0  = 0;
  int last_idx0    = -1;
  int onehot_err0  = 0;
  always @(negedge clk) begin
    if (FrameStrobe != '0) begin
      strobe_cyc0 <= strobe_cyc0 + 1;
      last_idx0   <= onehot_idx(FrameStrobe);
      if ($countones(FrameStrobe) != 1 || !busy) onehot_err0 <= onehot_err0 + 1;
    end
  end

  // dut1 monitor: every pulse is one cycle wide and framed by low cycles
  // with the expected data already (and still) present.
  int            pulse_q[$];
  int            onehot_err1 = 0;
  int            frame_err1  = 0;
  logic [31:0]   exp_data1   = '0;
  logic [NS-1:0] prev_strobe1 = '0;
  logic [31:0]   prev_data1   = '0;
  logic          prev_busy1   = 1'b0;
  always @(negedge clk) begin
    prev_strobe1 <= FrameStrobe1;
    prev_data1   <= FrameData1;
    prev_busy1   <= busy1;
    if (FrameStrobe1 != '0) begin
      pulse_q.push_back(onehot_idx(FrameStrobe1));
      if ($countones(FrameStrobe1) != 1) onehot_err1 <= onehot_err1 + 1;
      if (prev_strobe1 != '0 || !prev_busy1 || prev_data1 != exp_data1 ||
          FrameData1 != exp_data1)
        frame_err1 <= frame_err1 + 1;
    end else if (prev_strobe1 != '0) begin
      if (!busy1 || FrameData1 != exp_data1) frame_err1 <= frame_err1 + 1;
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send0(input logic [31:0] w);
    int n = 0;
    in_data = w; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("send0_ready_timeout", 0, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send1(input logic [31:0] w);
    int n = 0;
    in_data1 = w; in_valid1 = 1'b1;
    while (!in_ready1 && n < 50) begin @(negedge clk); n++; end
    if (!in_ready1) check("send1_ready_timeout", 0, 1);
    @(posedge clk); @(negedge clk);
    in_valid1 = 1'b0;
  endtask

  typedef struct {
    logic [31:0] word;
    int          exp_idx;   // -1: no strobe expected
    int          exp_gap;   // cycles in_ready stays low afterwards
    logic [31:0] exp_data;
    logic        exp_sync;
    logic        exp_err;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int gap, s0, n;

    vecs[0]  = '{32'h1234_5678, -1, 0, 32'h0,         1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0000, -1, 0, 32'h0,         1'b0, 1'b0};
    vecs[2]  = '{32'hFAB0_FAB1, -1, 0, 32'h0,         1'b1, 1'b0};
    vecs[3]  = '{32'h0000_0000, -1, 0, 32'h0,         1'b1, 1'b0};
    vecs[4]  = '{32'hCAFE_F00D,  0, 4, 32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[5]  = '{32'h0100_0003, -1, 0, 32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[6]  = '{32'hDEAD_BEEF, 23, 4, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[7]  = '{32'hFAB0_FAB1, -1, 0, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[8]  = '{32'h0400_0000, -1, 0, 32'hDEAD_BEEF, 1'b1, 1'b1};
    vecs[9]  = '{32'h55AA_55AA, -1, 0, 32'hDEAD_BEEF, 1'b1, 1'b1};
    vecs[10] = '{32'h0000_0014, -1, 0, 32'hDEAD_BEEF, 1'b1, 1'b1};
    vecs[11] = '{32'h1111_1111, -1, 0, 32'hDEAD_BEEF, 1'b1, 1'b1};
    vecs[12] = '{32'h0300_0013, -1, 0, 32'hDEAD_BEEF, 1'b1, 1'b1};
    vecs[13] = '{32'hA5A5_A5A5, 79, 4, 32'hA5A5_A5A5, 1'b1, 1'b1};
    vecs[14] = '{32'hFF00_0000, -1, 0, 32'hA5A5_A5A5, 1'b0, 1'b1};
    vecs[15] = '{32'h0000_0001, -1, 0, 32'hA5A5_A5A5, 1'b0, 1'b1};
    vecs[16] = '{32'h1212_1212, -1, 0, 32'hA5A5_A5A5, 1'b0, 1'b1};
    vecs[17] = '{32'hFAB0_FAB1, -1, 0, 32'hA5A5_A5A5, 1'b1, 1'b0};
    vecs[18] = '{32'h0200_0005, -1, 0, 32'hA5A5_A5A5, 1'b1, 1'b0};
    vecs[19] = '{32'h0BAD_C0DE, 45, 4, 32'h0BAD_C0DE, 1'b1, 1'b0};

    resetn = 1'b0; resetn1 = 1'b0;
    in_data = '0; in_valid = 1'b0; in_data1 = '0; in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_strobe", FrameStrobe, 0);
    check("rst_data",   FrameData,   0);
    check("rst_sync",   sync_lock,   0);
    check("rst_busy",   busy,        0);
    check("rst_err",    err_addr,    0);
    check("rst_ready",  in_ready,    1);
    resetn = 1'b1; resetn1 = 1'b1;
    @(negedge clk);

    // ---------------- table-driven stream on dut0 ----------------
    for (int i = 0; i < 20; i++) begin
      s0 = strobe_cyc0;
      send0(vecs[i].word);
      gap = 0;
      while (!in_ready && gap < 50) begin gap++; @(negedge clk); end
      check($sformatf("v%0d_gap", i), gap, vecs[i].exp_gap);
      check($sformatf("v%0d_strobe_cycles", i), strobe_cyc0 - s0,
            (vecs[i].exp_idx >= 0) ? 2 : 0);
      check($sformatf("v%0d_strobe_idx", i),
            (strobe_cyc0 != s0) ? last_idx0 : -1, vecs[i].exp_idx);
      check($sformatf("v%0d_data", i), FrameData, vecs[i].exp_data);
      check($sformatf("v%0d_sync", i), sync_lock, vecs[i].exp_sync);
      check($sformatf("v%0d_err", i),  err_addr,  vecs[i].exp_err);
    end
    check("onehot0", onehot_err0, 0);
`ifdef CFG_FRAME_COUNT_EN
    check("frames_written0", frames_written, 1);
`endif

    // ---------------- mid-strobe asynchronous reset ----------------
    send0(32'h0000_0002);
    send0(32'h7777_7777);
    n = 0;
    while (FrameStrobe == '0 && n < 10) begin @(negedge clk); n++; end
    check("mid_strobe_seen", FrameStrobe, NS'(1) << 2);
    resetn = 1'b0;
    #1;
    check("mid_rst_strobe", FrameStrobe, 0);
    check("mid_rst_data",   FrameData,   0);
    check("mid_rst_busy",   busy,        0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready,  1);
    check("post_rst_sync",  sync_lock, 0);
    send0(32'h0000_0000);
    check("post_rst_hunt_discard", sync_lock, 0);
    send0(32'hFAB0_FAB1);
    check("post_rst_resync", sync_lock, 1);
    check("post_rst_data",   FrameData, 0);

    // ---------------- back-to-back writes on dut1 (STROBE_CYCLES=1) ----------
    send1(32'hFAB0_FAB1);
    for (int f = 0; f < 20; f++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send1(32'h0100_0000 | 32'(f));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      exp_data1 = {8'(f), 8'hA5, 8'(f), 8'h5A};
      send1(exp_data1);
    end
    n = 0;
    while (!in_ready1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    check("b2b_pulse_count", pulse_q.size(), 20);
    for (int f = 0; f < 20 && f < pulse_q.size(); f++)
      check($sformatf("b2b_idx%0d", f), pulse_q[f], 20 + f);
    check("b2b_onehot",  onehot_err1, 0);
    check("b2b_framing", frame_err1,  0);
    check("b2b_final_data", FrameData1, {8'd19, 8'hA5, 8'd19, 8'h5A});
`ifdef CFG_FRAME_COUNT_EN
    check("frames_written1", frames_written1, 20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/config_frame_writer.md
Name: config_frame_writer

Overview:
- Configuration loader that sits directly upstream of the configuration-memory latch array.
- Accepts a 32-bit configuration word stream over a valid/ready handshake and hunts for the sync word.
- Decodes address/data word pairs, drives stable frame data onto the latch D inputs, and pulses exactly one frame strobe (latch enable E) per frame.
- Timing guarantees setup and hold of data around every strobe, so the level-sensitive latches capture cleanly.

Parameters:
- FRAME_BITS, 32, width of a frame word and of FrameData.
- NUM_COLUMNS, 4, number of fabric columns addressable.
- FRAMES_PER_COL, 20, frames per column; one strobe line per frame per column.
- STROBE_CYCLES, 2, number of cycles a frame strobe is held high (legal range 1..15).
- SYNC_WORD, 32'hFAB0_FAB1, pattern that starts a configuration session.

Ports:
- CLK  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- in_data  input  32  configuration word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- FrameData  output  FRAME_BITS  data driven to latch D inputs.
- FrameStrobe  output  NUM_COLUMNS*FRAMES_PER_COL  one-hot latch enables; index = col*FRAMES_PER_COL + frame.
- sync_lock  output  1  high while a session is active.
- busy  output  1  high in SETUP/STROBE/HOLD.
- err_addr  output  1  sticky out-of-range address flag.

Behaviour:
- Reset:
  - Asserting resetn low takes effect immediately, mid-strobe included.
  - Forces state HUNT, FrameStrobe=0, FrameData=0, sync_lock=0, busy=0, err_addr=0.
- Handshake:
  - A word transfers on a rising CLK edge with in_valid && in_ready.
  - in_ready=1 in HUNT, ADDR and DATA; 0 in SETUP, STROBE and HOLD.
  - in_ready does not depend combinationally on in_valid.
- HUNT:
  - Accepted words are discarded.
  - A word equal to SYNC_WORD moves to ADDR and sets sync_lock.
- ADDR: decodes the accepted word as col=in_data[31:24], frame=in_data[7:0].
  - col==8'hFF: desync; go to HUNT, clear sync_lock.
  - Word == SYNC_WORD: ignored; stay in ADDR.
  - Otherwise: latch col/frame and go to DATA.
  - col>=NUM_COLUMNS or frame>=FRAMES_PER_COL: set err_addr and mark the pending write as dropped.
- DATA:
  - Accepted word is registered into FrameData, then go to SETUP.
  - If the write is marked dropped, FrameData is unchanged and the state goes straight to ADDR.
- SETUP: one cycle, strobe low, FrameData stable.
- STROBE:
  - Exactly one FrameStrobe bit is high for STROBE_CYCLES cycles, driven from a register (glitch-free).
  - A down-counter sized for 15 times the strobe.
- HOLD: one cycle, strobe low, FrameData still stable; then go to ADDR.
- Latency:
  - Data word accepted at edge T: FrameData valid from T+1.
  - Strobe high from T+2 through T+1+STROBE_CYCLES.
  - in_ready high again at T+3+STROBE_CYCLES.
- FrameData persistence: FrameData holds its last value outside write sequences and is never cleared except by reset.
- err_addr: cleared only by reset or by a fresh SYNC_WORD accepted in HUNT.
- Idle stream: in_valid low in any accepting state means stall with no state change; no timeout.
- Strobe exclusivity: FrameStrobe never has more than one bit high, and is all-zero outside STROBE.

Optional Feature:
- Macro: CFG_FRAME_COUNT_EN.
- Defined:
  - Adds output frames_written[15:0], reset to 0.
  - Increments on the first cycle of each STROBE and saturates at 16'hFFFF.
  - Cleared when SYNC_WORD is accepted in HUNT.
  - Dropped writes do not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Sync and single write (defaults):
  - Stimulus: FAB0FAB1, 0x0100_0003, 0xDEADBEEF, back-to-back valid.
  - Response: FrameData=0xDEADBEEF from T+1; FrameStrobe bit 23 high for exactly 2 cycles at T+2..T+3; in_ready low T+1..T+4.
- Pre-sync garbage:
  - Stimulus: 0x12345678 and 0x0000_0000 before the sync word, then a write to col 0 frame 0.
  - Response: no strobe before sync; sync_lock rises the cycle after the sync word; only bit 0 strobes.
- Out-of-range address:
  - Stimulus: address 0x0400_0000 (col 4), then data 0x55AA55AA.
  - Response: err_addr=1 sticky; no strobe; FrameData unchanged; next valid pair writes normally.
- Desync and resync:
  - Stimulus: 0xFF00_0000.
  - Response: sync_lock=0; a following 0x0000_0001 / data pair produces no strobe until FAB0FAB1 is re-sent, which also clears err_addr.
- Mid-strobe reset:
  - Stimulus: resetn low during the first strobe cycle.
  - Response: FrameStrobe=0 and FrameData=0 immediately (asynchronously); state HUNT after release.
- Back-to-back writes with random in_valid gaps:
  - Stimulus: STROBE_CYCLES=1; 20 frames to col 1, frames 0..19.
  - Response: strobes appear in order on bits 20..39, one-hot, each preceded and followed by one low cycle with stable data; frames_written=20 when CFG_FRAME_COUNT_EN is defined.
